// File: rtl/hit_judge_pkg.sv
// rtl/hit_judge_pkg.sv - shared types and constants for the whack-a-mole hit judge
//
// Package wam_pkg:
//   judge_state_t : judge FSM states (IDLE, ARMED, JUDGED)
//   pos_t         : 4-bit light / key position index
//   KEY_MAX       : highest valid key / light index
//   LIVES_MAX     : highest loadable lives value
//   clamp_lives() : limits a requested lives value to LIVES_MAX

package wam_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        JUDGED = 2'd2
    } judge_state_t;

    typedef logic [3:0] pos_t;

    localparam pos_t KEY_MAX   = 4'd8;
    localparam pos_t LIVES_MAX = 4'd9;

    function automatic pos_t clamp_lives(input pos_t value);
        return (value > LIVES_MAX) ? LIVES_MAX : value;
    endfunction

endpackage

// File: rtl/hit_judge_sat_counter.sv
// rtl/hit_judge_sat_counter.sv - saturating up/down counter with synchronous load
//
// Module sat_counter
//   Parameters: W (counter width), MAX (upper saturation value)
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_value (highest priority)
//   load_value : value taken on load
//   inc        : count up, holding at MAX
//   dec        : count down, holding at 0 (ignored when inc is high)
//   count      : current value

module sat_counter #(
    parameter int W   = 6,
    parameter int MAX = 63
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (inc) begin
            if (count < MAX_V) begin
                count <= count + W'(1);
            end
        end else if (dec) begin
            if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

endmodule

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - judges keypad presses against the lit light, keeps score and lives
//
// Module hit_judge
//   Parameters: SCORE_W (score width), SCORE_MAX (score saturation),
//               PENALIZE_IDLE (1: a press with no light lit costs a life)
//   clk, reset   : clock, asynchronous active-high reset
//   enable       : game is in PLAY; low forces IDLE and freezes score/lives
//   light_on     : a light is lit
//   light_pos    : index of the lit light
//   key_valid    : one-cycle strobe for a keypad press
//   key          : pressed key index (9-15 are ignored)
//   load         : start a new game (score=0, lives=lives_init clamped to 9)
//   lives_init   : lives value taken on load
//   score        : hits so far
//   lives_left   : remaining lives
//   hit_pulse    : one-cycle hit strobe
//   miss_pulse   : one-cycle miss / wrong-press strobe
//   out_of_lives : lives_left == 0
//   streak       : consecutive hits (only with HIT_JUDGE_STREAK_EN defined)

module hit_judge
    import wam_pkg::*;
#(
    parameter int SCORE_W       = 6,
    parameter int SCORE_MAX     = 63,
    parameter int PENALIZE_IDLE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               light_on,
    input  pos_t               light_pos,
    input  logic               key_valid,
    input  pos_t               key,
    input  logic               load,
    input  pos_t               lives_init,
    output logic [SCORE_W-1:0] score,
    output pos_t               lives_left,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               out_of_lives
`ifdef HIT_JUDGE_STREAK_EN
    ,
    output logic [SCORE_W-1:0] streak
`endif
);

    judge_state_t state;
    judge_state_t next_state;
    pos_t         pos_q;
    pos_t         next_pos;
    logic         hit_ev;
    logic         miss_ev;
    logic         press;

    // Keys above KEY_MAX are not real buttons and never count as a press.
    assign press = key_valid && (key <= KEY_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pos_q      <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= next_state;
            pos_q      <= next_pos;
            hit_pulse  <= hit_ev;
            miss_pulse <= miss_ev;
        end
    end

    // Events are only raised when load is low and enable is high, so load
    // and enable-low automatically suppress pulses and counter updates.
    always_comb begin
        next_state = state;
        next_pos   = pos_q;
        hit_ev     = 1'b0;
        miss_ev    = 1'b0;
        if (load || !enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (light_on) begin
                        next_state = ARMED;
                        next_pos   = light_pos;
                    end else if (press && (PENALIZE_IDLE != 0)) begin
                        miss_ev = 1'b1;
                    end
                end
                ARMED: begin
                    // A press is judged first, even in the cycle the light
                    // falls, so a correct late press wins over the timeout.
                    if (press) begin
                        hit_ev     = (key == pos_q);
                        miss_ev    = (key != pos_q);
                        next_state = JUDGED;
                    end else if (!light_on) begin
                        miss_ev    = 1'b1;
                        next_state = IDLE;
                    end else if (light_pos != pos_q) begin
                        // Light moved unanswered: miss, then track the new one.
                        miss_ev  = 1'b1;
                        next_pos = light_pos;
                    end
                end
                JUDGED: begin
                    if (!light_on) begin
                        next_state = IDLE;
                    end else if (light_pos != pos_q) begin
                        next_state = ARMED;
                        next_pos   = light_pos;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    sat_counter #(
        .W   (SCORE_W),
        .MAX (SCORE_MAX)
    ) u_score (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value ('0),
        .inc        (hit_ev),
        .dec        (1'b0),
        .count      (score)
    );

    sat_counter #(
        .W   (4),
        .MAX (LIVES_MAX)
    ) u_lives (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (clamp_lives(lives_init)),
        .inc        (1'b0),
        .dec        (miss_ev),
        .count      (lives_left)
    );

    assign out_of_lives = (lives_left == '0);

`ifdef HIT_JUDGE_STREAK_EN
    sat_counter #(
        .W   (SCORE_W),
        .MAX (SCORE_MAX)
    ) u_streak (
        .clk        (clk),
        .reset      (reset),
        .load       (load || miss_ev),
        .load_value ('0),
        .inc        (hit_ev),
        .dec        (1'b0),
        .count      (streak)
    );
`endif

endmodule
